tas_frame_fifo: RTL and testbench

Per-console buffer for TAS input frames, between the serial handler and one n64_controller. Stores 32-bit controller frames written by the host link and presents the head frame to the console-side controller, popping one per console poll. Generates a refill request toward the serial handler when occupancy runs low, and defines the underrun output so a console never stalls on a starved queue.

---
 rtl/tas_frame_fifo.sv | 143 ++++++++++++++
 tb/tb_tas_frame_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tas_frame_fifo.sv
// TAS controller-frame FIFO between the serial handler and one n64_controller.
// Define TAS_FIFO_REPEAT_EN to repeat the last popped frame on underrun.
module tas_frame_fifo #(
  parameter int ADDR_W    = 4,
  parameter int LOW_WATER = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [31:0]       rd_data,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              refill_req,
  output logic              overflow,
  output logic [15:0]       underrun_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LW_CNT   = (ADDR_W+1)'(LOW_WATER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN
  } state_t;

  logic [31:0]     r_mem [DEPTH];
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  state_t          r_state;
  logic            r_full;
  logic            r_refill_req;
  logic            r_overflow;
  logic [15:0]     r_underrun_cnt;
  logic [31:0]     r_rd_data;

  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;
  logic            w_under;
  logic [ADDR_W:0] w_wr_ptr_nxt;
  logic [ADDR_W:0] w_rd_ptr_nxt;
  logic [ADDR_W:0] w_cnt_nxt;
  state_t          w_state_nxt;
  logic [31:0]     w_head_nxt;

  assign w_empty = (r_state == S_IDLE);
  assign w_push  = wr_en && (!r_full || rd_en);
  assign w_pop   = rd_en && !w_empty;
  assign w_drop  = wr_en && r_full && !rd_en;
  assign w_under = rd_en && w_empty;

  assign w_wr_ptr_nxt = r_wr_ptr + (ADDR_W+1)'(w_push);
  assign w_rd_ptr_nxt = r_rd_ptr + (ADDR_W+1)'(w_pop);
  assign w_cnt_nxt    = w_wr_ptr_nxt - w_rd_ptr_nxt;

  always_comb begin
    w_state_nxt = S_RUN;
    if (w_cnt_nxt == '0)
      w_state_nxt = S_IDLE;
    else if (w_cnt_nxt < LW_CNT)
      w_state_nxt = S_FILL;
  end

  // New head: the slot being written this cycle must come from wr_data.
  always_comb begin
    w_head_nxt = r_rd_data;
    if (w_pop) begin
      if (w_cnt_nxt == '0) begin
`ifdef TAS_FIFO_REPEAT_EN
        w_head_nxt = r_rd_data;
`else
        w_head_nxt = '0;
`endif
      end else if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
        w_head_nxt = wr_data;
      end else begin
        w_head_nxt = r_mem[w_rd_ptr_nxt[ADDR_W-1:0]];
      end
    end else if (w_push && w_empty) begin
      w_head_nxt = wr_data;
    end else if (w_under) begin
`ifdef TAS_FIFO_REPEAT_EN
      w_head_nxt = r_rd_data;
`else
      w_head_nxt = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush)
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_state        <= S_IDLE;
      r_full         <= 1'b0;
      r_refill_req   <= 1'b0;
      r_overflow     <= 1'b0;
      r_underrun_cnt <= '0;
      r_rd_data      <= '0;
    end else if (flush) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_state        <= S_IDLE;
      r_full         <= 1'b0;
      r_refill_req   <= 1'b0;
      r_overflow     <= 1'b0;
      r_underrun_cnt <= '0;
      r_rd_data      <= '0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_state      <= w_state_nxt;
      r_full       <= (w_cnt_nxt == FULL_CNT);
      r_refill_req <= (w_state_nxt != S_RUN);
      r_rd_data    <= w_head_nxt;
      if (w_drop)
        r_overflow <= 1'b1;
      if (w_under && (r_underrun_cnt != 16'hFFFF))
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign full         = r_full;
  assign empty        = w_empty;
  assign count        = r_wr_ptr - r_rd_ptr;
  assign rd_data      = r_rd_data;
  assign refill_req   = r_refill_req;
  assign overflow     = r_overflow;
  assign underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_tas_frame_fifo.sv
// Directed table-driven bench for tas_frame_fifo (depth 16, low water 4).
// Build with or without TAS_FIFO_REPEAT_EN; expectations follow the define.
module tb_tas_frame_fifo;

`ifdef TAS_FIFO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        full;
  logic        empty;
  logic        refill_req;
  logic        overflow;
  logic [31:0] rd_data;
  logic [4:0]  count;
  logic [15:0] underrun_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tas_frame_fifo #(
    .ADDR_W(4),
    .LOW_WATER(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .empty(empty),
    .count(count),
    .refill_req(refill_req),
    .overflow(overflow),
    .underrun_cnt(underrun_cnt)
  );

  typedef struct {
    logic        fl;
    logic        we;
    logic        re;
    logic [31:0] d;
    logic        ef;
    logic        ee;
    logic [4:0]  ec;
    logic [31:0] erd;
    logic        erf;
    logic        eov;
    logic [15:0] eur;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic fl, input logic we, input logic re,
                     input logic [31:0] d, input logic ef, input logic ee,
                     input int ec, input logic [31:0] erd, input logic erf,
                     input logic eov, input int eur);
    vec_t v;
    v.fl = fl; v.we = we; v.re = re; v.d = d;
    v.ef = ef; v.ee = ee; v.ec = 5'(ec); v.erd = erd;
    v.erf = erf; v.eov = eov; v.eur = 16'(eur);
    tbl.push_back(v);
  endtask

  function automatic logic [56:0] outs();
    return {full, empty, count, rd_data, refill_req, overflow, underrun_cnt};
  endfunction

  task automatic check(input string nm, input logic [56:0] got,
                       input logic [56:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {full,empty,count,rd_data,refill,ovf,urun}=%h required %h",
               nm, got, exp);
    end
  endtask

  initial begin
    // idle after reset
    for (int k = 0; k < 3; k++)
      add(0,0,0,0, 0,1,0,32'h0,1,0,0);
    // fill to full, then a dropped write
    for (int k = 1; k <= 16; k++)
      add(0,1,0,32'(k), k==16,0,k,32'h1,k<4,0,0);
    add(0,1,0,32'hFF, 1,0,16,32'h1,0,1,0);
    // drain in order
    for (int j = 1; j <= 16; j++)
      add(0,0,1,0, 0,j==16,16-j,
          (j < 16) ? 32'(j+1) : (REP ? 32'd16 : 32'd0),
          (16-j) < 4,1,0);
    add(1,0,0,0, 0,1,0,32'h0,0,0,0);
    add(0,0,0,0, 0,1,0,32'h0,1,0,0);
    // simultaneous push/pop while full
    for (int k = 1; k <= 16; k++)
      add(0,1,0,32'(32'h100+k), k==16,0,k,32'h101,k<4,0,0);
    add(0,1,1,32'hAA, 1,0,16,32'h102,0,0,0);
    for (int j = 1; j <= 15; j++)
      add(0,0,1,0, 0,0,16-j,
          (j < 15) ? 32'(32'h102+j) : 32'hAA,
          (16-j) < 4,0,0);
    add(1,0,0,0, 0,1,0,32'h0,0,0,0);
    add(0,0,0,0, 0,1,0,32'h0,1,0,0);
    // underrun value
    add(0,1,0,32'h1234_5678, 0,0,1,32'h1234_5678,1,0,0);
    add(0,0,1,0, 0,1,0,REP ? 32'h1234_5678 : 32'h0,1,0,0);
    add(0,0,1,0, 0,1,0,REP ? 32'h1234_5678 : 32'h0,1,0,1);
    add(1,0,0,0, 0,1,0,32'h0,0,0,0);
    add(0,0,0,0, 0,1,0,32'h0,1,0,0);
    // refill watermark
    for (int k = 1; k <= 5; k++)
      add(0,1,0,32'(32'h200+k), 0,0,k,32'h201,k<4,0,0);
    add(0,0,1,0, 0,0,4,32'h202,0,0,0);
    add(0,0,1,0, 0,0,3,32'h203,1,0,0);
    add(1,0,0,0, 0,1,0,32'h0,0,0,0);
    add(0,0,0,0, 0,1,0,32'h0,1,0,0);
    // push+pop on empty: push taken, pop is underrun
    add(0,1,1,32'h55, 0,0,1,32'h55,1,0,1);
    add(0,0,1,0, 0,1,0,REP ? 32'h55 : 32'h0,1,0,1);
    for (int k = 1; k <= 6; k++)
      add(0,1,0,32'(32'h300+k), 0,0,k,32'h301,k<4,0,1);
    // flush with concurrent strobes discards them
    add(1,1,1,32'h3FF, 0,1,0,32'h0,0,0,0);
    add(0,0,0,0, 0,1,0,32'h0,1,0,0);

    #1;
    check("reset_state", outs(), {1'b0,1'b1,5'd0,32'h0,1'b0,1'b0,16'h0});
    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      flush = tbl[i].fl;
      wr_en = tbl[i].we;
      rd_en = tbl[i].re;
      wr_data = tbl[i].d;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), outs(),
            {tbl[i].ef, tbl[i].ee, tbl[i].ec, tbl[i].erd,
             tbl[i].erf, tbl[i].eov, tbl[i].eur});
    end

    // asynchronous reset in the middle of a write burst
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      flush = 1'b0;
      rd_en = 1'b0;
      wr_en = 1'b1;
      wr_data = 32'h400 + 32'(k);
      @(posedge clk);
      #1;
    end
    check("burst_pre_reset", outs(),
          {1'b0,1'b0,5'd3,32'h400,1'b1,1'b0,16'h0});
    #1;
    reset = 1'b1;
    #1;
    check("async_reset", outs(), {1'b0,1'b1,5'd0,32'h0,1'b0,1'b0,16'h0});
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_refill", outs(),
          {1'b0,1'b1,5'd0,32'h0,1'b1,1'b0,16'h0});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
